// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the 10G Ethernet TX path.
package eth_tx_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
    logic                   tuser;
  } axis64_beat_t;

  typedef enum logic [1:0] {IDLE, ARB, XFER, GAP} arb_state_t;

  // Index width that stays legal (>= 1 bit) even for a single element.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo N.
module rr_arbiter
  import eth_tx_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = idxWidth(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gntIdx_o
);

  int idx;

  // Scan from the farthest offset down so the request nearest the pointer wins last.
  always_comb begin
    gnt_o    = '0;
    gntIdx_o = '0;
    idx      = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % N;
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gntIdx_o   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic round-robin sharing of the MAC AXI-Stream TX port, with a post-frame idle gap
// and per-source completed-frame counters.
module eth_tx_frame_arbiter
  import eth_tx_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int GAP_CYCLES = 3,
  parameter int CNT_W      = 32,
  localparam int IDX_W = idxWidth(NUM_SRC),
  localparam int GAP_W = idxWidth(GAP_CYCLES + 1)
) (
  input  logic                             coreclk,
  input  logic                             tx_axis_aresetn,
  input  logic [NUM_SRC-1:0]               src_enable,
  input  logic [NUM_SRC*AXIS_DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_SRC*AXIS_KEEP_W-1:0]   s_axis_tkeep,
  input  logic [NUM_SRC-1:0]               s_axis_tlast,
  input  logic [NUM_SRC-1:0]               s_axis_tuser,
  input  logic [NUM_SRC-1:0]               s_axis_tvalid,
  output logic [NUM_SRC-1:0]               s_axis_tready,
  output logic [AXIS_DATA_W-1:0]           m_axis_tx_tdata,
  output logic [AXIS_KEEP_W-1:0]           m_axis_tx_tkeep,
  output logic                             m_axis_tx_tlast,
  output logic                             m_axis_tx_tuser,
  output logic                             m_axis_tx_tvalid,
  input  logic                             m_axis_tx_tready,
  output logic [IDX_W-1:0]                 grant_id,
  output logic                             busy,
  output logic [NUM_SRC*CNT_W-1:0]         frame_cnt
);

  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t         state_q;
  logic [IDX_W-1:0]   grantId_q;
  logic [IDX_W-1:0]   rrPtr_q;
  logic [IDX_W-1:0]   rrPtr_d;
  logic [GAP_W-1:0]   gapCnt_q;
  logic               busy_q;
  logic [CNT_W-1:0]   frameCnt_q [NUM_SRC];
  logic [CNT_W-1:0]   frameCnt_d [NUM_SRC];

  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] arbGnt;
  logic [IDX_W-1:0]   arbIdx;
  axis64_beat_t       selBeat;
  logic               selValid;
  logic               lastHs;

  assign req = s_axis_tvalid & src_enable;

  rr_arbiter #(.N(NUM_SRC)) uArb (
    .req_i    (req),
    .ptr_i    (rrPtr_q),
    .gnt_o    (arbGnt),
    .gntIdx_o (arbIdx)
  );

  // The granted source drives the MAC only in XFER; everything else sees zeros.
  always_comb begin
    selBeat       = '0;
    selValid      = 1'b0;
    s_axis_tready = '0;
    if (state_q == XFER) begin
      selBeat.tdata            = s_axis_tdata[int'(grantId_q)*AXIS_DATA_W +: AXIS_DATA_W];
      selBeat.tkeep            = s_axis_tkeep[int'(grantId_q)*AXIS_KEEP_W +: AXIS_KEEP_W];
      selBeat.tlast            = s_axis_tlast[grantId_q];
      selBeat.tuser            = s_axis_tuser[grantId_q];
      selValid                 = s_axis_tvalid[grantId_q];
      s_axis_tready[grantId_q] = m_axis_tx_tready;
    end
  end

  assign lastHs  = selValid & m_axis_tx_tready & selBeat.tlast;
  assign rrPtr_d = (grantId_q == IDX_W'(NUM_SRC - 1)) ? '0 : grantId_q + 1'b1;

  always_ff @(posedge coreclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      state_q   <= IDLE;
      grantId_q <= '0;
      rrPtr_q   <= '0;
      gapCnt_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req) state_q <= ARB;
        end
        ARB: begin
          if (|arbGnt) begin
            grantId_q <= arbIdx;
            state_q   <= XFER;
            busy_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        XFER: begin
          if (lastHs) begin
            rrPtr_q <= rrPtr_d;
            if (GAP_CYCLES == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= GAP;
              gapCnt_q <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gapCnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gapCnt_q <= gapCnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counters wrap silently; an aborted (tuser) frame still counts once its tlast is accepted.
  always_comb begin
    frameCnt_d = frameCnt_q;
    if (lastHs) frameCnt_d[grantId_q] = frameCnt_q[grantId_q] + CNT_W'(1);
  end

  always_ff @(posedge coreclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      for (int i = 0; i < NUM_SRC; i++) frameCnt_q[i] <= '0;
    end else begin
      frameCnt_q <= frameCnt_d;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : gCnt
    assign frame_cnt[g*CNT_W +: CNT_W] = frameCnt_q[g];
  end

  assign m_axis_tx_tdata  = selBeat.tdata;
  assign m_axis_tx_tkeep  = selBeat.tkeep;
  assign m_axis_tx_tlast  = selBeat.tlast;
  assign m_axis_tx_tuser  = selBeat.tuser;
  assign m_axis_tx_tvalid = selValid;
  assign grant_id         = grantId_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter: a gap-3 instance and a gap-0 instance share the source stimulus.
module tb_eth_tx_frame_arbiter;

  localparam int NS = 4;
  localparam int CW = 32;

  logic              clk = 1'b0;
  logic              rstN;
  logic [NS-1:0]     srcEnable, sTvalid, sTlast, sTuser;
  logic [NS*64-1:0]  sTdata;
  logic [NS*8-1:0]   sTkeep;
  logic              macReady;

  logic [NS-1:0]     sTready, nSTready;
  logic [63:0]       mTdata, nTdata;
  logic [7:0]        mTkeep, nTkeep;
  logic              mTlast, mTuser, mTvalid, nTlast, nTuser, nTvalid;
  logic [1:0]        grantId, nGrantId;
  logic              busy, nBusy;
  logic [NS*CW-1:0]  frameCnt, nFrameCnt;

  int          frLen [NS];
  int          frLeft [NS];
  int          beatIdx [NS];
  int          frNo [NS];
  logic        stall [NS];
  logic        userFlag [NS];
  logic [NS-1:0] enMask;
  bit          useNoGap;
  int          cyc;
  int          nVec, nFail;

  logic [63:0] hsData [$];
  int          hsSrc [$];
  logic        hsLast [$];
  int          hsCyc [$];
  logic        busyTr [$];
  logic        validTr [$];

  logic [63:0]   lastData;
  logic [7:0]    lastKeep;
  logic          lastLast, lastUser, lastValid, lastBusy;
  logic [1:0]    lastGrant;
  logic [NS-1:0] lastSReady;

  always #5 clk = ~clk;

  eth_tx_frame_arbiter #(.NUM_SRC(NS), .GAP_CYCLES(3), .CNT_W(CW)) dut (
    .coreclk(clk), .tx_axis_aresetn(rstN), .src_enable(srcEnable),
    .s_axis_tdata(sTdata), .s_axis_tkeep(sTkeep), .s_axis_tlast(sTlast),
    .s_axis_tuser(sTuser), .s_axis_tvalid(sTvalid), .s_axis_tready(sTready),
    .m_axis_tx_tdata(mTdata), .m_axis_tx_tkeep(mTkeep), .m_axis_tx_tlast(mTlast),
    .m_axis_tx_tuser(mTuser), .m_axis_tx_tvalid(mTvalid), .m_axis_tx_tready(macReady),
    .grant_id(grantId), .busy(busy), .frame_cnt(frameCnt)
  );

  eth_tx_frame_arbiter #(.NUM_SRC(NS), .GAP_CYCLES(0), .CNT_W(CW)) dutNoGap (
    .coreclk(clk), .tx_axis_aresetn(rstN), .src_enable(srcEnable),
    .s_axis_tdata(sTdata), .s_axis_tkeep(sTkeep), .s_axis_tlast(sTlast),
    .s_axis_tuser(sTuser), .s_axis_tvalid(sTvalid), .s_axis_tready(nSTready),
    .m_axis_tx_tdata(nTdata), .m_axis_tx_tkeep(nTkeep), .m_axis_tx_tlast(nTlast),
    .m_axis_tx_tuser(nTuser), .m_axis_tx_tvalid(nTvalid), .m_axis_tx_tready(macReady),
    .grant_id(nGrantId), .busy(nBusy), .frame_cnt(nFrameCnt)
  );

  function automatic logic [63:0] beatData(input int s, input int f, input int b);
    logic [7:0]  sb;
    logic [7:0]  fb;
    logic [15:0] bb;
    sb = 8'(s) + 8'hA0;
    fb = 8'(f);
    bb = 16'(b);
    return {sb, fb, bb, 32'hC0FFEE00};
  endfunction

  task automatic driveSources();
    for (int i = 0; i < NS; i++) begin
      logic isLast;
      isLast = (beatIdx[i] == frLen[i] - 1);
      sTvalid[i]         = (frLeft[i] > 0) && !stall[i];
      srcEnable[i]       = enMask[i] && !stall[i];
      sTdata[i*64 +: 64] = beatData(i, frNo[i], beatIdx[i]);
      sTkeep[i*8 +: 8]   = isLast ? 8'h0F : 8'hFF;
      sTlast[i]          = isLast;
      sTuser[i]          = isLast && userFlag[i];
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < NS; i++) begin
      frLen[i] = 1; frLeft[i] = 0; beatIdx[i] = 0; frNo[i] = 0;
      stall[i] = 1'b0; userFlag[i] = 1'b0;
    end
    enMask = '1;
    cyc = 0;
    hsData.delete(); hsSrc.delete(); hsLast.delete(); hsCyc.delete();
    busyTr.delete(); validTr.delete();
    driveSources();
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    macReady = 1'b1;
    resetModel();
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  // One clock per iteration: sample the selected instance at negedge, advance sources after posedge.
  task automatic applyStimulus(input int n);
    logic [NS-1:0] srcHs;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (useNoGap) begin
        lastValid = nTvalid; lastData = nTdata; lastKeep = nTkeep; lastLast = nTlast;
        lastUser = nTuser; lastGrant = nGrantId; lastBusy = nBusy; lastSReady = nSTready;
      end else begin
        lastValid = mTvalid; lastData = mTdata; lastKeep = mTkeep; lastLast = mTlast;
        lastUser = mTuser; lastGrant = grantId; lastBusy = busy; lastSReady = sTready;
      end
      busyTr.push_back(lastBusy);
      validTr.push_back(lastValid);
      if (lastValid && macReady) begin
        hsData.push_back(lastData);
        hsSrc.push_back(int'(lastGrant));
        hsLast.push_back(lastLast);
        hsCyc.push_back(cyc);
      end
      srcHs = sTvalid & lastSReady;
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NS; i++) begin
        if (srcHs[i]) begin
          beatIdx[i]++;
          if (beatIdx[i] == frLen[i]) begin
            beatIdx[i] = 0;
            frNo[i]++;
            frLeft[i]--;
          end
        end
      end
      driveSources();
    end
  endtask

  task automatic runUntilHs(input int n, input int bound, input string tag);
    int k = 0;
    while (hsSrc.size() < n && k < bound) begin
      applyStimulus(1);
      k++;
    end
    nVec++;
    if (hsSrc.size() < n) begin
      nFail++;
      $display("[TB] FAIL %s_timeout: got %0d handshakes, expected %0d", tag, hsSrc.size(), n);
    end
  endtask

  task automatic test_reset();
    resetDut();
    rstN = 1'b0;
    frLeft[0] = 1; frLeft[3] = 1;
    driveSources();
    #1;
    nVec++;
    if ({mTvalid, mTlast, mTuser, busy} !== 4'b0) begin
      nFail++; $display("[TB] FAIL reset_ctrl: got %b, expected 0000", {mTvalid, mTlast, mTuser, busy});
    end
    nVec++;
    if ({mTdata, mTkeep} !== 72'h0) begin
      nFail++; $display("[TB] FAIL reset_data: got %0h, expected 0", {mTdata, mTkeep});
    end
    nVec++;
    if (sTready !== 4'b0 || grantId !== 2'd0) begin
      nFail++; $display("[TB] FAIL reset_ready_grant: got %b/%0d, expected 0000/0", sTready, grantId);
    end
    nVec++;
    if (frameCnt !== '0) begin
      nFail++; $display("[TB] FAIL reset_counters: got %0h, expected 0", frameCnt);
    end
  endtask

  task automatic test_single_frame();
    int c;
    resetDut();
    frLen[0] = 3; frLeft[0] = 1;
    driveSources();
    applyStimulus(12);
    nVec++;
    if (hsSrc.size() !== 3) begin
      nFail++; $display("[TB] FAIL single_beats: got %0d, expected 3", hsSrc.size());
    end
    for (int b = 0; b < 3 && b < hsSrc.size(); b++) begin
      nVec++;
      if (hsData[b] !== beatData(0, 0, b) || hsLast[b] !== (b == 2) || hsSrc[b] !== 0) begin
        nFail++; $display("[TB] FAIL single_beat%0d: got %0h/%b/%0d, expected %0h/%b/0",
                          b, hsData[b], hsLast[b], hsSrc[b], beatData(0, 0, b), (b == 2));
      end
    end
    nVec++;
    if (hsCyc.size() > 0 && hsCyc[0] !== 2) begin
      nFail++; $display("[TB] FAIL single_latency: got %0d, expected 2", hsCyc[0]);
    end
    if (hsCyc.size() == 3) begin
      c = hsCyc[2];
      nVec++;
      if ({busyTr[c+1], busyTr[c+2], busyTr[c+3], busyTr[c+4]} !== 4'b1110 ||
          {validTr[c+1], validTr[c+2], validTr[c+3]} !== 3'b000) begin
        nFail++; $display("[TB] FAIL single_gap: got busy %b, expected 1110",
                          {busyTr[c+1], busyTr[c+2], busyTr[c+3], busyTr[c+4]});
      end
    end
    nVec++;
    if (frameCnt[0 +: CW] !== 32'd1 || grantId !== 2'd0) begin
      nFail++; $display("[TB] FAIL single_count: got %0d/%0d, expected 1/0", frameCnt[0 +: CW], grantId);
    end
  endtask

  task automatic test_round_robin();
    int c;
    resetDut();
    for (int i = 0; i < NS; i++) begin frLen[i] = 2; frLeft[i] = 2; end
    driveSources();
    applyStimulus(70);
    nVec++;
    if (hsSrc.size() !== 16) begin
      nFail++; $display("[TB] FAIL rr_beats: got %0d, expected 16", hsSrc.size());
    end
    for (int f = 0; f < 8 && 2*f + 1 < hsSrc.size(); f++) begin
      nVec++;
      if (hsSrc[2*f] !== f % NS || hsSrc[2*f+1] !== f % NS || hsLast[2*f+1] !== 1'b1) begin
        nFail++; $display("[TB] FAIL rr_order%0d: got %0d, expected %0d", f, hsSrc[2*f], f % NS);
      end
      if (2*f + 2 < hsCyc.size()) begin
        c = hsCyc[2*f+1];
        nVec++;
        if (hsCyc[2*f+2] - c !== 6 ||
            {busyTr[c+1], busyTr[c+2], busyTr[c+3], busyTr[c+4]} !== 4'b1110) begin
          nFail++; $display("[TB] FAIL rr_gap%0d: got spacing %0d busy %b, expected 6 1110", f,
                            hsCyc[2*f+2] - c, {busyTr[c+1], busyTr[c+2], busyTr[c+3], busyTr[c+4]});
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      nVec++;
      if (frameCnt[i*CW +: CW] !== 32'd2) begin
        nFail++; $display("[TB] FAIL rr_count%0d: got %0d, expected 2", i, frameCnt[i*CW +: CW]);
      end
    end
  endtask

  task automatic test_mid_frame_stall();
    int expSrc [6] = '{1, 1, 1, 1, 2, 2};
    int expBeat [6] = '{0, 1, 2, 3, 0, 1};
    resetDut();
    frLen[1] = 4; frLeft[1] = 1;
    frLen[2] = 2; frLeft[2] = 1;
    driveSources();
    applyStimulus(3);
    stall[1] = 1'b1;
    driveSources();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1);
      nVec++;
      if (lastGrant !== 2'd1 || lastValid !== 1'b0 || lastSReady[2] !== 1'b0 || lastBusy !== 1'b1) begin
        nFail++; $display("[TB] FAIL stall_hold%0d: got grant %0d valid %b, expected 1 0", k, lastGrant, lastValid);
      end
    end
    stall[1] = 1'b0;
    driveSources();
    applyStimulus(20);
    nVec++;
    if (hsSrc.size() !== 6) begin
      nFail++; $display("[TB] FAIL stall_beats: got %0d, expected 6", hsSrc.size());
    end
    for (int b = 0; b < 6 && b < hsSrc.size(); b++) begin
      nVec++;
      if (hsSrc[b] !== expSrc[b] || hsData[b] !== beatData(expSrc[b], 0, expBeat[b])) begin
        nFail++; $display("[TB] FAIL stall_seq%0d: got %0d/%0h, expected %0d/%0h", b, hsSrc[b], hsData[b],
                          expSrc[b], beatData(expSrc[b], 0, expBeat[b]));
      end
    end
    nVec++;
    if (frameCnt[1*CW +: CW] !== 32'd1 || frameCnt[2*CW +: CW] !== 32'd1) begin
      nFail++; $display("[TB] FAIL stall_count: got %0d/%0d, expected 1/1", frameCnt[1*CW +: CW], frameCnt[2*CW +: CW]);
    end
  endtask

  task automatic test_backpressure();
    int rp [6] = '{1, 0, 0, 1, 1, 1};
    int eb [6] = '{0, 1, 1, 1, 2, 3};
    logic [NS-1:0] expR;
    resetDut();
    frLen[0] = 4; frLeft[0] = 1; userFlag[0] = 1'b1;
    frLen[1] = 2; frLeft[1] = 1;
    driveSources();
    applyStimulus(2);
    for (int j = 0; j < 6; j++) begin
      macReady = rp[j][0];
      expR = NS'(rp[j]);
      applyStimulus(1);
      nVec++;
      if (lastValid !== 1'b1 || lastData !== beatData(0, 0, eb[j]) || lastSReady !== expR) begin
        nFail++; $display("[TB] FAIL bp_cycle%0d: got %0h ready %b, expected %0h ready %b", j,
                          lastData, lastSReady, beatData(0, 0, eb[j]), expR);
      end
    end
    nVec++;
    if ({lastLast, lastUser, lastKeep} !== {2'b11, 8'h0F}) begin
      nFail++; $display("[TB] FAIL bp_tail: got %b/%b/%0h, expected 1/1/0f", lastLast, lastUser, lastKeep);
    end
    macReady = 1'b1;
    applyStimulus(4);
    nVec++;
    if (hsSrc.size() < 4 || hsData[0] !== beatData(0, 0, 0) || hsData[1] !== beatData(0, 0, 1) ||
        hsData[2] !== beatData(0, 0, 2) || hsData[3] !== beatData(0, 0, 3)) begin
      nFail++; $display("[TB] FAIL bp_stream: got %0d beats, expected beats 0..3 once each", hsSrc.size());
    end
    nVec++;
    if (frameCnt[0 +: CW] !== 32'd1) begin
      nFail++; $display("[TB] FAIL bp_count: got %0d, expected 1", frameCnt[0 +: CW]);
    end
  endtask

  task automatic test_no_gap();
    int expSrc [4] = '{2, 3, 2, 3};
    resetDut();
    useNoGap = 1'b1;
    frLen[2] = 1; frLeft[2] = 2;
    frLen[3] = 1; frLeft[3] = 2;
    driveSources();
    applyStimulus(20);
    useNoGap = 1'b0;
    nVec++;
    if (hsSrc.size() !== 4) begin
      nFail++; $display("[TB] FAIL nogap_beats: got %0d, expected 4", hsSrc.size());
    end
    for (int k = 0; k < 4 && k < hsSrc.size(); k++) begin
      nVec++;
      if (hsSrc[k] !== expSrc[k] || hsCyc[k] !== 2 + 3*k) begin
        nFail++; $display("[TB] FAIL nogap_frame%0d: got src %0d cyc %0d, expected %0d %0d", k,
                          hsSrc[k], hsCyc[k], expSrc[k], 2 + 3*k);
      end
    end
    nVec++;
    if (busyTr[2] !== 1'b1 || busyTr[3] !== 1'b0) begin
      nFail++; $display("[TB] FAIL nogap_busy: got %b%b, expected 10", busyTr[2], busyTr[3]);
    end
    nVec++;
    if (nFrameCnt[2*CW +: CW] !== 32'd2 || nFrameCnt[3*CW +: CW] !== 32'd2) begin
      nFail++; $display("[TB] FAIL nogap_count: got %0d/%0d, expected 2/2", nFrameCnt[2*CW +: CW], nFrameCnt[3*CW +: CW]);
    end
  endtask

  task automatic test_reset_mid_frame();
    resetDut();
    frLen[0] = 1; frLeft[0] = 1;
    frLen[1] = 3; frLeft[1] = 1;
    driveSources();
    runUntilHs(2, 40, "rstmid_setup");
    #1;
    nVec++;
    if (mTvalid !== 1'b1 || grantId !== 2'd1 || frameCnt[0 +: CW] !== 32'd1) begin
      nFail++; $display("[TB] FAIL rstmid_pre: got valid %b grant %0d cnt %0d, expected 1 1 1",
                        mTvalid, grantId, frameCnt[0 +: CW]);
    end
    #1 rstN = 1'b0;
    #1;
    nVec++;
    if ({mTvalid, mTlast, mTuser, busy} !== 4'b0 || {mTdata, mTkeep} !== 72'h0 || sTready !== 4'b0) begin
      nFail++; $display("[TB] FAIL rstmid_outputs: got valid %b data %0h ready %b, expected 0 0 0000",
                        mTvalid, mTdata, sTready);
    end
    nVec++;
    if (grantId !== 2'd0 || frameCnt !== '0) begin
      nFail++; $display("[TB] FAIL rstmid_state: got grant %0d cnt %0h, expected 0 0", grantId, frameCnt);
    end
    resetModel();
    @(posedge clk);
    #1 rstN = 1'b1;
    frLen[0] = 1; frLeft[0] = 1;
    frLen[1] = 1; frLeft[1] = 1;
    driveSources();
    applyStimulus(2);
    #1;
    nVec++;
    if (grantId !== 2'd0 || busy !== 1'b1) begin
      nFail++; $display("[TB] FAIL rstmid_restart: got grant %0d busy %b, expected 0 1", grantId, busy);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nVec = 0;
    nFail = 0;
    useNoGap = 1'b0;
    macReady = 1'b1;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_mid_frame_stall();
    test_backpressure();
    test_no_gap();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
